alu_sweep_driver: RTL and testbench

Hardware exerciser for the 16-bit Hack ALU. On a start pulse it drives the operands and all 64 combinations of the six ALU control bits {zx,nx,zy,ny,f,no}, samples the ALU's out/zr/ng for each combination, and compresses the results into a MISR signature with flag counts and a flag-consistency error. It sits on the opposite side of the ALU interface, producing x/y/control and consuming out/zr/ng, for in-system self-test of the chapter-2 datapath.

---
 rtl/alu_pkg.sv | 33 +++
 rtl/alu_sweep_driver_if.sv | 21 ++
 rtl/misr16.sv | 27 ++
 rtl/alu_sweep_driver.sv | 90 +++++++++
 tb/tb_alu_sweep_driver.sv | 318 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/alu_pkg.sv
// Shared constants and types for the Hack ALU sweep exerciser.
package alu_pkg;

    localparam int ALU_W  = 16;
    localparam int CTRL_W = 6;
    localparam int CNT_W  = 7;

    // Bit positions inside alu_ctrl = {zx,nx,zy,ny,f,no}.
    localparam int ZX = 5;
    localparam int NX = 4;
    localparam int ZY = 3;
    localparam int NY = 2;
    localparam int F  = 1;
    localparam int NO = 0;

    localparam logic [CTRL_W-1:0] CTRL_LAST = '1;

    localparam logic [ALU_W-1:0] MISR_POLY_DEF = 16'hB400;
    localparam logic [ALU_W-1:0] MISR_SEED_DEF = 16'hFFFF;

    typedef enum logic [1:0] {
        S_IDLE,
        S_DRIVE,
        S_SAMPLE,
        S_DONE
    } state_t;

    // True when the reported flags disagree with the result they describe.
    function automatic logic flags_inconsistent(logic [ALU_W-1:0] out, logic zr, logic ng);
        return (zr != (out == '0)) || (ng != out[ALU_W-1]);
    endfunction

endpackage

// File: rtl/alu_sweep_driver_if.sv
// ALU-side bus: operands and control toward the ALU, result and flags back.
interface alu_sweep_driver_if;

    logic [alu_pkg::ALU_W-1:0]  alu_x;
    logic [alu_pkg::ALU_W-1:0]  alu_y;
    logic [alu_pkg::CTRL_W-1:0] alu_ctrl;
    logic [alu_pkg::ALU_W-1:0]  alu_out;
    logic                       alu_zr;
    logic                       alu_ng;

    modport master (
        output alu_x, alu_y, alu_ctrl,
        input  alu_out, alu_zr, alu_ng
    );

    modport slave (
        input  alu_x, alu_y, alu_ctrl,
        output alu_out, alu_zr, alu_ng
    );

endinterface

// File: rtl/misr16.sv
// Right-shifting Galois MISR: load puts SEED in, step folds one data word in.
module misr16
    import alu_pkg::*;
#(
    parameter logic [ALU_W-1:0] POLY = MISR_POLY_DEF,
    parameter logic [ALU_W-1:0] SEED = MISR_SEED_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic             step,
    input  logic [ALU_W-1:0] data,
    output logic [ALU_W-1:0] sig
);

    // NOTE: state is written with <= so every register sees pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sig <= '0;
        end else if (load) begin
            sig <= SEED;
        end else if (step) begin
            sig <= (sig >> 1) ^ (sig[0] ? POLY : '0) ^ data;
        end
    end

endmodule

// File: rtl/alu_sweep_driver.sv
// Walks all 64 ALU control words, two cycles each, and compacts the results.
module alu_sweep_driver
    import alu_pkg::*;
#(
    parameter int               WIDTH     = ALU_W,  // only 16 is supported
    parameter logic [ALU_W-1:0] MISR_POLY = MISR_POLY_DEF,
    parameter logic [ALU_W-1:0] MISR_SEED = MISR_SEED_DEF
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [WIDTH-1:0]   x_in,
    input  logic [WIDTH-1:0]   y_in,
    alu_sweep_driver_if.master alu,
    output logic               busy,
    output logic               done,
    output logic [ALU_W-1:0]   signature,
    output logic [CNT_W-1:0]   zr_count,
    output logic [CNT_W-1:0]   ng_count,
    output logic               flag_err
);

    state_t state, state_next;
    logic   accept;
    logic   sample;
    logic   last_ctrl;

    assign last_ctrl = (alu.alu_ctrl == CTRL_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_next;
    end

    // NOTE: default assignment first so no path through the case infers a latch.
    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:   if (start) state_next = S_DRIVE;
            S_DRIVE:  state_next = S_SAMPLE;
            S_SAMPLE: state_next = last_ctrl ? S_DONE : S_DRIVE;
            S_DONE:   state_next = S_IDLE;
            default:  state_next = S_IDLE;
        endcase
    end

    always_comb begin
        busy   = (state != S_IDLE);
        done   = (state == S_DONE);
        accept = (state == S_IDLE) && start;
        sample = (state == S_SAMPLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alu.alu_x    <= '0;
            alu.alu_y    <= '0;
            alu.alu_ctrl <= '0;
            zr_count     <= '0;
            ng_count     <= '0;
            flag_err     <= 1'b0;
        end else if (accept) begin
            alu.alu_x    <= x_in;
            alu.alu_y    <= y_in;
            alu.alu_ctrl <= '0;
            zr_count     <= '0;
            ng_count     <= '0;
            flag_err     <= 1'b0;
        end else if (sample) begin
            zr_count <= zr_count + CNT_W'(alu.alu_zr);
            ng_count <= ng_count + CNT_W'(alu.alu_ng);
            flag_err <= flag_err | flags_inconsistent(alu.alu_out, alu.alu_zr, alu.alu_ng);
            // Holding at the last word keeps the final combination visible in DONE.
            if (!last_ctrl) alu.alu_ctrl <= alu.alu_ctrl + 1'b1;
        end
    end

    misr16 #(
        .POLY (MISR_POLY),
        .SEED (MISR_SEED)
    ) u_misr (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (accept),
        .step  (sample),
        .data  (alu.alu_out),
        .sig   (signature)
    );

endmodule

// File: tb/tb_alu_sweep_driver.sv
// Self-checking bench: Hack ALU model on the bus, reference sweep model in plain code.
module tb_alu_sweep_driver;
    import alu_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [15:0] x_in = '0;
    logic [15:0] y_in = '0;
    logic        busy, done, flag_err;
    logic [15:0] signature;
    logic [6:0]  zr_count, ng_count;
    bit          fault_en = 1'b0;

    int n_cmp = 0;
    int n_err = 0;

    alu_sweep_driver_if bus();

    alu_sweep_driver #(
        .WIDTH     (16),
        .MISR_POLY (16'hB400),
        .MISR_SEED (16'hFFFF)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .x_in      (x_in),
        .y_in      (y_in),
        .alu       (bus.master),
        .busy      (busy),
        .done      (done),
        .signature (signature),
        .zr_count  (zr_count),
        .ng_count  (ng_count),
        .flag_err  (flag_err)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] hack_alu(logic [15:0] x, logic [15:0] y, logic [5:0] c);
        logic [15:0] a, b, r;
        a = c[5] ? 16'd0 : x;
        if (c[4]) a = ~a;
        b = c[3] ? 16'd0 : y;
        if (c[2]) b = ~b;
        r = c[1] ? a + b : a & b;
        if (c[0]) r = ~r;
        return r;
    endfunction

    // Combinational ALU on the far side of the bus, with an optional zr fault at ctrl 42.
    always_comb begin
        logic [15:0] r;
        r = hack_alu(bus.alu_x, bus.alu_y, bus.alu_ctrl);
        bus.alu_out = r;
        bus.alu_zr  = (r == 16'd0) && !(fault_en && bus.alu_ctrl == 6'd42);
        bus.alu_ng  = r[15];
    end

    task automatic ref_sweep(input logic [15:0] x, input logic [15:0] y, input bit fault,
                             output logic [15:0] sig, output logic [6:0] zr,
                             output logic [6:0] ng, output logic err);
        logic [15:0] o;
        logic        z, g;
        sig = 16'hFFFF;
        zr  = 0;
        ng  = 0;
        err = 0;
        for (int c = 0; c < 64; c++) begin
            o   = hack_alu(x, y, 6'(c));
            z   = (o == 0) && !(fault && c == 42);
            g   = o[15];
            sig = (sig >> 1) ^ (sig[0] ? 16'hB400 : 16'h0000) ^ o;
            zr  = zr + 7'(z);
            ng  = ng + 7'(g);
            err = err | (z != (o == 0)) | (g != o[15]);
        end
    endtask

    logic [15:0] obs_out [64];
    logic [5:0]  obs_ctrl[64];
    int          first_done, done_cnt;
    logic        busy_first, busy_after;
    logic [15:0] res_sig;
    logic [6:0]  res_zr, res_ng;
    logic        res_err;

    // Ends at the falling edge right after the accepting rising edge E0.
    task automatic begin_sweep(input logic [15:0] x, input logic [15:0] y);
        @(negedge clk);
        start = 1'b1;
        x_in  = x;
        y_in  = y;
        @(negedge clk);
        start = 1'b0;
        busy_first = busy;
    endtask

    // Observes cycle n after E0 at each falling edge; stops tail cycles after done.
    task automatic finish_sweep(input bit jitter, input int extra_at, input int tail);
        first_done = -1;
        done_cnt   = 0;
        busy_after = 1'bx;
        for (int n = 1; n <= 200; n++) begin
            @(negedge clk);
            if (jitter) begin
                x_in = 16'($urandom);
                y_in = 16'($urandom);
            end
            start = (n == extra_at);
            if (n % 2 == 1 && n <= 127) begin
                obs_ctrl[(n - 1) / 2] = bus.alu_ctrl;
                obs_out[(n - 1) / 2]  = bus.alu_out;
            end
            if (done) begin
                done_cnt++;
                if (first_done < 0) begin
                    first_done = n;
                    res_sig = signature;
                    res_zr  = zr_count;
                    res_ng  = ng_count;
                    res_err = flag_err;
                end
            end
            if (first_done >= 0 && n == first_done + 1) busy_after = busy;
            if (first_done >= 0 && n >= first_done + tail) break;
        end
        start = 1'b0;
    endtask

    task automatic check_results(input string tag, input logic [15:0] x, input logic [15:0] y,
                                 input bit fault);
        logic [15:0] e_sig;
        logic [6:0]  e_zr, e_ng;
        logic        e_err;
        ref_sweep(x, y, fault, e_sig, e_zr, e_ng, e_err);
        n_cmp++;
        if (first_done !== 128) begin
            n_err++;
            $display("FAIL %s_done_cycle: actual %0d required 128", tag, first_done);
        end
        n_cmp++;
        if (res_sig !== e_sig) begin
            n_err++;
            $display("FAIL %s_signature: actual %h required %h", tag, res_sig, e_sig);
        end
        n_cmp++;
        if ({res_zr, res_ng, res_err} !== {e_zr, e_ng, e_err}) begin
            n_err++;
            $display("FAIL %s_counts: actual zr=%0d ng=%0d err=%b required zr=%0d ng=%0d err=%b",
                     tag, res_zr, res_ng, res_err, e_zr, e_ng, e_err);
        end
    endtask

    task automatic test_reset();
        #12;
        n_cmp++;
        if ({bus.alu_x, bus.alu_y, bus.alu_ctrl, busy, done} !== 40'd0) begin
            n_err++;
            $display("FAIL reset_bus: actual x=%h y=%h ctrl=%h busy=%b done=%b required all 0",
                     bus.alu_x, bus.alu_y, bus.alu_ctrl, busy, done);
        end
        n_cmp++;
        if ({signature, zr_count, ng_count, flag_err} !== 31'd0) begin
            n_err++;
            $display("FAIL reset_result: actual sig=%h zr=%0d ng=%0d err=%b required all 0",
                     signature, zr_count, ng_count, flag_err);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_normal_sweep();
        logic [15:0] e_sig;
        logic [6:0]  e_zr, e_ng;
        logic        e_err;
        int          bad_ctrl;
        begin_sweep(16'd9, 16'd15);
        finish_sweep(1'b0, 0, 3);
        check_results("normal", 16'd9, 16'd15, 1'b0);
        n_cmp++;
        if ({obs_out[42], obs_out[63], obs_out[2], obs_out[19]} !== {16'd0, 16'd1, 16'd24, 16'hFFFA}) begin
            n_err++;
            $display("FAIL normal_known_outs: actual %h %h %h %h required 0000 0001 0018 fffa",
                     obs_out[42], obs_out[63], obs_out[2], obs_out[19]);
        end
        bad_ctrl = 0;
        for (int k = 0; k < 64; k++) if (obs_ctrl[k] !== 6'(k)) bad_ctrl++;
        n_cmp++;
        if (bad_ctrl != 0) begin
            n_err++;
            $display("FAIL normal_ctrl_order: actual %0d out-of-order words required 0", bad_ctrl);
        end
        n_cmp++;
        if ({busy_first, busy_after, 6'(done_cnt)} !== {1'b1, 1'b0, 6'd1}) begin
            n_err++;
            $display("FAIL normal_busy_done: actual busy0=%b busy129=%b pulses=%0d required 1 0 1",
                     busy_first, busy_after, done_cnt);
        end
        ref_sweep(16'd9, 16'd15, 1'b0, e_sig, e_zr, e_ng, e_err);
        n_cmp++;
        if ({signature, zr_count, done} !== {e_sig, e_zr, 1'b0}) begin
            n_err++;
            $display("FAIL normal_hold: actual sig=%h zr=%0d done=%b required sig=%h zr=%0d done=0",
                     signature, zr_count, done, e_sig, e_zr);
        end
    endtask

    task automatic test_fault_injection();
        logic [15:0] g_sig;
        logic [6:0]  g_zr, g_ng;
        logic        g_err;
        ref_sweep(16'd9, 16'd15, 1'b0, g_sig, g_zr, g_ng, g_err);
        fault_en = 1'b1;
        begin_sweep(16'd9, 16'd15);
        finish_sweep(1'b0, 0, 1);
        fault_en = 1'b0;
        n_cmp++;
        if ({res_err, res_zr, res_sig} !== {1'b1, 7'(g_zr - 7'd1), g_sig}) begin
            n_err++;
            $display("FAIL fault_effect: actual err=%b zr=%0d sig=%h required err=1 zr=%0d sig=%h",
                     res_err, res_zr, res_sig, g_zr - 7'd1, g_sig);
        end
    endtask

    task automatic test_start_while_busy();
        begin_sweep(16'd9, 16'd15);
        finish_sweep(1'b0, 50, 10);
        check_results("busy_start", 16'd9, 16'd15, 1'b0);
        n_cmp++;
        if (done_cnt !== 1) begin
            n_err++;
            $display("FAIL busy_start_pulses: actual %0d required 1", done_cnt);
        end
    endtask

    task automatic test_reset_mid_sweep();
        int pulses;
        begin_sweep(16'd9, 16'd15);
        repeat (70) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({bus.alu_x, bus.alu_y, bus.alu_ctrl, busy, done, signature, zr_count, ng_count, flag_err}
            !== 71'd0) begin
            n_err++;
            $display("FAIL midreset_outputs: actual x=%h y=%h ctrl=%h busy=%b sig=%h zr=%0d ng=%0d required all 0",
                     bus.alu_x, bus.alu_y, bus.alu_ctrl, busy, signature, zr_count, ng_count);
        end
        pulses = 0;
        for (int n = 0; n < 80; n++) begin
            @(negedge clk);
            if (n == 3) rst_n = 1'b1;
            if (done) pulses++;
        end
        n_cmp++;
        if (pulses !== 0 || busy !== 1'b0) begin
            n_err++;
            $display("FAIL midreset_quiet: actual pulses=%0d busy=%b required 0 0", pulses, busy);
        end
        begin_sweep(16'd9, 16'd15);
        finish_sweep(1'b0, 0, 1);
        check_results("midreset_restart", 16'd9, 16'd15, 1'b0);
    endtask

    task automatic test_back_to_back_zero();
        begin_sweep(16'd0, 16'd0);
        finish_sweep(1'b0, 0, 0);
        check_results("zero_first", 16'd0, 16'd0, 1'b0);
        begin_sweep(16'd0, 16'd0);
        n_cmp++;
        if ({zr_count, ng_count, flag_err, busy} !== {7'd0, 7'd0, 1'b0, 1'b1}) begin
            n_err++;
            $display("FAIL zero_reinit: actual zr=%0d ng=%0d err=%b busy=%b required 0 0 0 1",
                     zr_count, ng_count, flag_err, busy);
        end
        finish_sweep(1'b0, 0, 1);
        check_results("zero_second", 16'd0, 16'd0, 1'b0);
    endtask

    task automatic test_operand_latching();
        logic [15:0] x, y;
        begin_sweep(16'd9, 16'd15);
        finish_sweep(1'b1, 0, 1);
        check_results("latch_fixed", 16'd9, 16'd15, 1'b0);
        x = 16'($urandom);
        y = 16'($urandom);
        begin_sweep(x, y);
        finish_sweep(1'b1, 0, 1);
        check_results("latch_random", x, y, 1'b0);
    endtask

    task automatic test_random_operands();
        logic [15:0] x, y;
        for (int i = 0; i < 3; i++) begin
            x = 16'($urandom);
            y = (i == 0) ? x : 16'($urandom);
            begin_sweep(x, y);
            finish_sweep(1'b0, 0, 1);
            check_results($sformatf("random%0d", i), x, y, 1'b0);
        end
    endtask

    initial begin
        test_reset();
        test_normal_sweep();
        test_fault_injection();
        test_start_while_busy();
        test_reset_mid_sweep();
        test_back_to_back_zero();
        test_operand_latching();
        test_random_operands();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
